// File: rtl/polytris_text_pkg.sv
// polytris_text_pkg: shared geometry, ASCII constants and converter types for the score panel.
package polytris_text_pkg;
    localparam int CELL_W = 8;
    localparam int CELL_H = 16;
    localparam int PANEL_COLS = 7;
    localparam int PANEL_ROWS = 6;
    localparam logic [5:0] SCORE_DIGIT_BASE = 6'd29;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
    typedef logic [4:0][3:0] bcd_digits_t;
endpackage

// File: rtl/score_bcd.sv
// score_bcd: sequential double-dabble converter; DIGITS only change once a full conversion completes.
module score_bcd
    import polytris_text_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] SCORE,
    output bcd_digits_t DIGITS,
    output logic        BUSY
);
    bcd_state_t state, state_n;
    logic [15:0] bin, bin_n, cap, cap_n, last_score, last_n;
    logic [19:0] bcd, bcd_n, adj;
    logic [3:0] count, count_n;
    bcd_digits_t digits_n;
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            bin <= '0;
            cap <= '0;
            bcd <= '0;
            count <= '0;
            last_score <= '0;
            DIGITS <= '0;
        end else begin
            state <= state_n;
            bin <= bin_n;
            cap <= cap_n;
            bcd <= bcd_n;
            count <= count_n;
            last_score <= last_n;
            DIGITS <= digits_n;
        end
    end
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 5; i++) adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        state_n = state;
        bin_n = bin;
        cap_n = cap;
        bcd_n = bcd;
        count_n = count;
        last_n = last_score;
        digits_n = DIGITS;
        case (state)
            IDLE: if (SCORE != last_score) begin
                state_n = SHIFT;
                bin_n = SCORE;
                cap_n = SCORE;
                bcd_n = '0;
                count_n = '0;
            end
            SHIFT: begin
                {bcd_n, bin_n} = {adj, bin} << 1;
                count_n = count + 4'd1;
                state_n = count == 4'd15 ? DONE : SHIFT;
            end
            DONE: begin
                digits_n = bcd;
                last_n = cap;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign BUSY = state != IDLE;
endmodule

// File: rtl/score_panel_render.sv
// score_panel_render: 3-stage text-panel renderer with live score overlay on row 4.
// Define SCORE_LZB_EN to blank leading zeros of the score (d0 always shown).
module score_panel_render
    import polytris_text_pkg::*;
#(
    parameter logic [9:0] PANEL_X0 = 10'd584,
    parameter logic [9:0] PANEL_Y0 = 10'd16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  DRAW_X,
    input  logic [9:0]  DRAW_Y,
    input  logic [15:0] SCORE,
    output logic [5:0]  CHAR_ADDR,
    input  logic [7:0]  CHAR_DATA,
    output logic [10:0] FONT_ADDR,
    input  logic [7:0]  FONT_DATA,
    output logic        PIXEL_ON,
    output logic        IN_PANEL,
    output logic        BCD_BUSY
);
    bcd_digits_t digits;
    logic [9:0] dx, dy;
    logic in_now;
    logic [2:0] s1_col, s1_row, s1_bit, s2_bit, pos;
    logic [3:0] s1_sub, s2_sub;
    logic s1_in, s2_in, is_digit;
    logic [5:0] digit_idx;
    logic [4:0] lead_zero;
    logic [7:0] sel_char, s2_char;
    logic unused_ok;
    score_bcd u_bcd (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .SCORE(SCORE),
        .DIGITS(digits),
        .BUSY(BCD_BUSY)
    );
    assign dx = DRAW_X - PANEL_X0;
    assign dy = DRAW_Y - PANEL_Y0;
    assign in_now = DRAW_X >= PANEL_X0 && dx < 10'(PANEL_COLS * CELL_W) && DRAW_Y >= PANEL_Y0 && dy < 10'(PANEL_ROWS * CELL_H);
    assign CHAR_ADDR = s1_in ? {3'b0, s1_row} * 6'd7 + {3'b0, s1_col} : 6'd0;
`ifdef SCORE_LZB_EN
    assign lead_zero = {digits[4] == 4'd0, digits[4:3] == 8'd0, digits[4:2] == 12'd0, digits[4:1] == 16'd0, 1'b0};
`else
    assign lead_zero = '0;
`endif
    always_comb begin
        digit_idx = CHAR_ADDR - SCORE_DIGIT_BASE;
        is_digit = CHAR_ADDR >= SCORE_DIGIT_BASE && CHAR_ADDR < SCORE_DIGIT_BASE + 6'd5;
        pos = 3'd4 - digit_idx[2:0];
        sel_char = is_digit ? (lead_zero[pos] ? 8'h00 : ASCII_ZERO + {4'b0, digits[pos]}) : CHAR_DATA;
    end
    assign FONT_ADDR = {s2_char[6:0], s2_sub};
    assign unused_ok = ^{s2_char[7], digit_idx[5:3]};
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            {s1_col, s1_row, s1_bit, s1_sub, s1_in} <= '0;
            {s2_char, s2_bit, s2_sub, s2_in} <= '0;
            PIXEL_ON <= 1'b0;
            IN_PANEL <= 1'b0;
        end else begin
            s1_col <= dx[5:3];
            s1_row <= dy[6:4];
            s1_bit <= dx[2:0];
            s1_sub <= dy[3:0];
            s1_in <= in_now;
            s2_char <= sel_char;
            s2_bit <= s1_bit;
            s2_sub <= s1_sub;
            s2_in <= s1_in;
            PIXEL_ON <= s2_in & FONT_DATA[3'd7 - s2_bit];
            IN_PANEL <= s2_in;
        end
    end
endmodule

// File: tb/tb_score_panel_render.sv
// tb_score_panel_render: randomized self-checking bench against an arithmetic model of the panel.
module tb_score_panel_render;
    logic CLK = 0, RESET_N = 0, fixed_font = 0;
    logic [9:0] DRAW_X = 0, DRAW_Y = 0;
    logic [15:0] SCORE = 0;
    logic [5:0] CHAR_ADDR;
    logic [7:0] CHAR_DATA, FONT_DATA;
    logic [10:0] FONT_ADDR;
    logic PIXEL_ON, IN_PANEL, BCD_BUSY;
    logic [7:0] text [42];
    int n_checks = 0, n_fail = 0, shown = 0;
    typedef struct packed {logic in; logic [5:0] addr; logic [10:0] fa; logic px;} exp_t;
    exp_t q[$];

    score_panel_render dut (
        .CLK(CLK), .RESET_N(RESET_N), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y), .SCORE(SCORE),
        .CHAR_ADDR(CHAR_ADDR), .CHAR_DATA(CHAR_DATA), .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
        .PIXEL_ON(PIXEL_ON), .IN_PANEL(IN_PANEL), .BCD_BUSY(BCD_BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] font_rom(input logic [10:0] a);
        return a[10:4] == 7'd0 ? 8'h00 : 8'(a * 37) ^ {1'b1, a[10:4]};
    endfunction

    assign CHAR_DATA = CHAR_ADDR < 6'd42 ? text[CHAR_ADDR] : 8'hFF;
    assign FONT_DATA = fixed_font ? 8'h81 : font_rom(FONT_ADDR);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int n);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_char(input int addr);
        int p, w;
        if (addr < 29 || addr > 33) return text[addr];
        p = 33 - addr;
        w = 10 ** p;
`ifdef SCORE_LZB_EN
        if (p > 0 && shown < w) return 8'h00;
`endif
        return 8'h30 + 8'((shown / w) % 10);
    endfunction

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        logic [7:0] ch, f;
        int a;
        e = '0;
        e.in = x >= 584 && x < 640 && y >= 16 && y < 112;
        if (!e.in) return e;
        a = ((y - 16) / 16) * 7 + (x - 584) / 8;
        e.addr = 6'(a);
        ch = exp_char(a);
        e.fa = {ch[6:0], 4'((y - 16) % 16)};
        f = fixed_font ? 8'h81 : font_rom(e.fa);
        e.px = f[7 - (x - 584) % 8];
        return e;
    endfunction

    task automatic pix(input int x, input int y);
        exp_t e;
        @(posedge CLK);
        #1;
        if (q.size() == 3) begin
            e = q.pop_front();
            check("pixel_on", PIXEL_ON, e.px);
            check("in_panel", IN_PANEL, e.in);
        end
        if (q.size() >= 1) check("char_addr", CHAR_ADDR, q[q.size()-1].addr);
        if (q.size() >= 2 && q[q.size()-2].in) check("font_addr", FONT_ADDR, q[q.size()-2].fa);
        DRAW_X = 10'(x);
        DRAW_Y = 10'(y);
        q.push_back(model(x, y));
    endtask

    task automatic sweep(input int x0, input int x1, input int y0, input int y1);
        q.delete();
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) pix(x, y);
        repeat (3) pix(0, 0);
    endtask

    task automatic conv(input logic [15:0] v, input int chg_at, input logic [15:0] v2);
        int old;
        old = shown;
        SCORE = v;
        for (int k = 0; k <= 17; k++) begin
            @(posedge CLK);
            #1;
            if (k == chg_at) SCORE = v2;
            check("bcd_busy", BCD_BUSY, 32'(k < 17));
            check("digits", dut.digits, k < 17 ? to_bcd(old) : to_bcd(int'(v)));
        end
        shown = int'(v);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 42; i++) text[i] = 8'($urandom_range(33, 126));
        for (int i = 28; i < 35; i++) text[i] = 8'h00;
        for (int i = 7; i < 14; i++) text[i] = 8'h20;
        text[8] = "S"; text[9] = "C"; text[10] = "O"; text[11] = "R"; text[12] = "E";
        DRAW_X = 10'd600;
        DRAW_Y = 10'd40;
        SCORE = 16'd0;
        repeat (4) @(posedge CLK);
        #1;
        check("rst_pixel_on", PIXEL_ON, 0);
        check("rst_in_panel", IN_PANEL, 0);
        check("rst_char_addr", CHAR_ADDR, 0);
        check("rst_busy", BCD_BUSY, 0);
        check("rst_digits", dut.digits, 0);
        RESET_N = 1;
        @(posedge CLK);
        #1;
        check("idle_after_rst_score0", BCD_BUSY, 0);
        sweep(576, 647, 8, 119);
        for (int i = 0; i < 300; i++) pix($urandom_range(0, 799), $urandom_range(0, 524));
        conv(16'd12345, -1, 16'd0);
        sweep(576, 647, 78, 97);
        conv(16'd65535, -1, 16'd0);
        sweep(584, 639, 80, 95);
        conv(16'd7, -1, 16'd0);
        sweep(584, 639, 80, 95);
        conv(16'd100, 5, 16'd200);
        conv(16'd200, -1, 16'd0);
        sweep(584, 639, 80, 95);
        SCORE = 16'd999;
        for (int k = 0; k <= 8; k++) begin
            @(posedge CLK);
            #1;
        end
        check("busy_mid_conv", BCD_BUSY, 1);
        RESET_N = 0;
        @(posedge CLK);
        #1;
        check("abort_digits", dut.digits, 0);
        check("abort_busy", BCD_BUSY, 0);
        check("abort_pixel_on", PIXEL_ON, 0);
        check("abort_in_panel", IN_PANEL, 0);
        check("abort_char_addr", CHAR_ADDR, 0);
        RESET_N = 1;
        shown = 0;
        conv(16'd999, -1, 16'd0);
        sweep(584, 639, 80, 95);
        fixed_font = 1;
        sweep(576, 647, 14, 50);
        fixed_font = 0;
        for (int n = 0; n < 8; n++) begin
            v = 16'($urandom);
            if (n == 0) v = 16'd120;
            if (int'(v) == shown) v = v ^ 16'd1;
            conv(v, -1, 16'd0);
            q.delete();
            for (int i = 0; i < 300; i++) pix($urandom_range(570, 660), $urandom_range(0, 130));
            sweep(584, 639, 80, 95);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
